// File: rtl/dcache_wb.sv
// dcache_wb: N-way set-associative write-back data cache with true-LRU replacement and miss FSM.
// Defining CACHE_STATS_EN adds hit/miss counters with a clear input.
module dcache_wb #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128,
    parameter int WAYS   = 4,
    parameter int SETS   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic              req_byte_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       stat_hits_o,
    output logic [31:0]       stat_misses_o
`endif
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(SETS);
    localparam int IW    = IDX_W > 0 ? IDX_W : 1;
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WW    = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, EVICT, REFILL, RESP} state_t;
    state_t state;

    logic [LINE_W-1:0] data  [SETS][WAYS];
    logic [TAG_W-1:0]  tags  [SETS][WAYS];
    logic [WW-1:0]     age   [SETS][WAYS];
    logic [WAYS-1:0]   valid [SETS];
    logic [WAYS-1:0]   dirty [SETS];

    logic [ADDR_W-1:0] c_addr;
    logic              c_write, c_byte;
    logic [31:0]       c_wdata;
    logic [WW-1:0]     c_way;

    function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return SETS == 1 ? '0 : IW'(a >> OFF_W);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF_W + IDX_W));
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(input logic [TAG_W-1:0] t, input logic [IW-1:0] i);
        return (ADDR_W'(t) << (OFF_W + IDX_W)) | (ADDR_W'(i) << OFF_W);
    endfunction

    function automatic logic [31:0] rd(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] o, input logic b);
        logic [31:0] w;
        w = l[{o[OFF_W-1:2], 5'b0} +: 32];
        return b ? {24'b0, w[{o[1:0], 3'b0} +: 8]} : w;
    endfunction

    function automatic logic [LINE_W-1:0] wr(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] o,
                                             input logic b, input logic [31:0] d);
        logic [LINE_W-1:0] r;
        r = l;
        if (b) r[{o, 3'b0} +: 8] = d[7:0];
        else r[{o[OFF_W-1:2], 5'b0} +: 32] = d;
        return r;
    endfunction

    // Touched way becomes most recent; ways that were newer slide down by one.
    task automatic touch(input logic [IW-1:0] i, input logic [WW-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (WW'(w) == t) age[i][w] <= WW'(WAYS - 1);
            else if (age[i][w] > age[i][t]) age[i][w] <= age[i][w] - 1'b1;
    endtask

    logic [IW-1:0]    r_idx, c_idx;
    logic [TAG_W-1:0] r_tag;
    logic [WW-1:0]    hit_way, vic_way;
    logic             hit, any_inv, accept;

    assign accept = req_valid_i && req_ready_o;
    assign c_idx  = idx_of(c_addr);

    always_comb begin
        r_idx   = idx_of(req_addr_i);
        r_tag   = tag_of(req_addr_i);
        hit     = 1'b0;
        hit_way = '0;
        vic_way = '0;
        any_inv = 1'b0;
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[r_idx][w] && tags[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid[r_idx][w]) begin
                any_inv = 1'b1;
                vic_way = WW'(w);
            end else if (!any_inv && age[r_idx][w] == '0) vic_way = WW'(w);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= WW'(w);
            end
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (hit) begin
                        if (req_write_i) begin
                            data[r_idx][hit_way]  <= wr(data[r_idx][hit_way], OFF_W'(req_addr_i), req_byte_i, req_wdata_i);
                            dirty[r_idx][hit_way] <= 1'b1;
                        end else rsp_data_o <= rd(data[r_idx][hit_way], OFF_W'(req_addr_i), req_byte_i);
                        touch(r_idx, hit_way);
                        rsp_valid_o <= 1'b1;
                    end else begin
                        c_addr      <= req_addr_i;
                        c_write     <= req_write_i;
                        c_byte      <= req_byte_i;
                        c_wdata     <= req_wdata_i;
                        c_way       <= vic_way;
                        req_ready_o <= 1'b0;
                        mem_req_o   <= 1'b1;
                        if (valid[r_idx][vic_way] && dirty[r_idx][vic_way]) begin
                            state       <= EVICT;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= line_of(tags[r_idx][vic_way], r_idx);
                            mem_wdata_o <= data[r_idx][vic_way];
                        end else begin
                            state      <= REFILL;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= line_of(r_tag, r_idx);
                        end
                    end
                end
                EVICT: if (mem_ready_i) begin
                    state      <= REFILL;
                    mem_we_o   <= 1'b0;
                    mem_addr_o <= line_of(tag_of(c_addr), c_idx);
                end
                REFILL: if (mem_ready_i) begin
                    data[c_idx][c_way]  <= mem_rdata_i;
                    tags[c_idx][c_way]  <= tag_of(c_addr);
                    valid[c_idx][c_way] <= 1'b1;
                    dirty[c_idx][c_way] <= 1'b0;
                    touch(c_idx, c_way);
                    mem_req_o <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (c_write) begin
                        data[c_idx][c_way]  <= wr(data[c_idx][c_way], OFF_W'(c_addr), c_byte, c_wdata);
                        dirty[c_idx][c_way] <= 1'b1;
                    end else rsp_data_o <= rd(data[c_idx][c_way], OFF_W'(c_addr), c_byte);
                    rsp_valid_o <= 1'b1;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else if (accept) begin
            if (hit) stat_hits_o <= stat_hits_o + 1'b1;
            else stat_misses_o <= stat_misses_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed + random accesses against a line-level LRU cache model and backing memory.
module tb_dcache_wb;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_valid_i = 1'b0, req_write_i = 1'b0, req_byte_i = 1'b0;
    logic [19:0]  req_addr_i = '0;
    logic [31:0]  req_wdata_i = '0;
    logic         req_ready_o, rsp_valid_o, mem_req_o, mem_we_o;
    logic [31:0]  rsp_data_o;
    logic [19:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ready_i = 1'b0;
    logic [127:0] mem_rdata_i = '0;
`ifdef CACHE_STATS_EN
    logic         stat_clr_i = 1'b0;
    logic [31:0]  stat_hits_o, stat_misses_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_wb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
`ifdef CACHE_STATS_EN
        , .stat_clr_i(stat_clr_i), .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
    );

    int errors = 0, checks = 0;
    int n_hit = 0, n_miss = 0;
    logic [127:0] bmem [int];
    logic [127:0] cl [int];
    bit           dl [int];
    int           lru [4][$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [127:0] bread(input int la);
        logic [31:0] a;
        a = 32'(la);
        return bmem.exists(la) ? bmem[la] : {a ^ 32'hC300_0003, a ^ 32'hC200_0002, a ^ 32'hC100_0001, a ^ 32'hC000_0000};
    endfunction

    task automatic model_reset();
        cl.delete();
        dl.delete();
        for (int s = 0; s < 4; s++) lru[s].delete();
        n_hit = 0;
        n_miss = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic do_access(input bit w, input bit b, input int addr, input logic [31:0] wd, input int dly);
        int la, s, off, pos, vla, lat, seen, cnt, nreq;
        bit hit, ev, is_wb;
        logic [127:0] line, vdata, sv_data;
        logic [31:0] exp;
        logic [19:0] sv_addr;
        la = addr & ~15;
        s = (addr >> 4) & 3;
        off = addr & 15;
        pos = -1;
        ev = 1'b0;
        vla = 0;
        vdata = '0;
        for (int i = 0; i < lru[s].size(); i++) if (lru[s][i] == la) pos = i;
        hit = pos >= 0;
        if (hit) begin
            lru[s].delete(pos);
            n_hit++;
        end else begin
            n_miss++;
            if (lru[s].size() == 4) begin
                vla = lru[s].pop_front();
                ev = dl[vla];
                vdata = cl[vla];
                if (ev) bmem[vla] = vdata;
                cl.delete(vla);
                dl.delete(vla);
            end
            cl[la] = bread(la);
            dl[la] = 1'b0;
        end
        lru[s].push_back(la);
        line = cl[la];
        exp = b ? {24'b0, line[off*8 +: 8]} : line[(off >> 2)*32 +: 32];
        if (w) begin
            if (b) line[off*8 +: 8] = wd[7:0];
            else line[(off >> 2)*32 +: 32] = wd;
            cl[la] = line;
            dl[la] = 1'b1;
        end
        nreq = hit ? 0 : 1 + int'(ev);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_byte_i = b;
        req_addr_i = 20'(addr);
        req_wdata_i = wd;
        tick();
        req_valid_i = 1'b0;
        lat = 1;
        seen = 0;
        cnt = 0;
        sv_addr = '0;
        sv_data = '0;
        while (!rsp_valid_o && lat < 60) begin
            chk("req_ready_busy", req_ready_o, 0);
            if (mem_req_o) begin
                if (cnt == 0) begin
                    if (seen >= nreq) chk("extra_mem_req", 1, 0);
                    is_wb = seen == 0 && ev;
                    chk("mem_we", mem_we_o, is_wb);
                    chk("mem_addr", mem_addr_o, is_wb ? 20'(vla) : 20'(la));
                    if (is_wb) chk("wb_data", mem_wdata_o, vdata);
                    sv_addr = mem_addr_o;
                    sv_data = mem_wdata_o;
                end else begin
                    chk("mem_addr_stable", mem_addr_o, sv_addr);
                    chk("mem_wdata_stable", mem_wdata_o, sv_data);
                end
                if (cnt == dly) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mem_we_o ? '0 : bread(la);
                    seen++;
                    cnt = 0;
                end else cnt++;
            end
            tick();
            mem_ready_i = 1'b0;
            lat++;
        end
        chk("rsp_valid", rsp_valid_o, 1);
        chk("latency", lat, hit ? 1 : 3 + int'(ev) + dly * nreq);
        chk("mem_req_count", seen, nreq);
        chk("req_ready_after", req_ready_o, 1);
        if (!w) chk("rsp_data", rsp_data_o, exp);
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);

        bmem[32'h10] = 128'h44444444_33333333_22222222_11111111;
        do_access(0, 0, 32'h14, 0, 0);
        chk("first_word", rsp_data_o, 32'h22222222);
        do_access(1, 1, 32'h13, 32'h000000AB, 0);
        do_access(0, 1, 32'h13, 0, 0);
        chk("byte_load", rsp_data_o, 32'h000000AB);

        do_access(1, 0, 32'h00, 32'hDEADBEEF, 0);
        do_access(0, 0, 32'h40, 0, 0);
        do_access(0, 0, 32'h84, 0, 1);
        do_access(0, 1, 32'hC5, 0, 0);
        do_access(0, 0, 32'h100, 0, 5);
        do_access(0, 0, 32'h00, 0, 2);
        chk("evicted_readback", rsp_data_o, 32'hDEADBEEF);

        for (int i = 0; i < 150; i++)
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15)),
                      $urandom, int'($urandom_range(0, 3)));

        do_reset();
        chk("req_ready_pre_abort", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_byte_i = 1'b0;
        req_addr_i = 20'h300;
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (!(mem_req_o && !mem_we_o) && n < 10) begin
            tick();
            n++;
        end
        chk("abort_fill_seen", mem_req_o && !mem_we_o, 1);
        chk("abort_fill_addr", mem_addr_o, 20'h300);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        model_reset();
        chk("abort_mem_req", mem_req_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", rsp_valid_o, 0);
            tick();
        end
        do_access(0, 0, 32'h300, 0, 0);
        do_access(0, 0, 32'h304, 0, 0);

`ifdef CACHE_STATS_EN
        chk("stat_hits", stat_hits_o, 32'(n_hit));
        chk("stat_misses", stat_misses_o, 32'(n_miss));
        stat_clr_i = 1'b1;
        do_access(0, 0, 32'h308, 0, 0);
        stat_clr_i = 1'b0;
        chk("stat_clr_hits", stat_hits_o, 0);
        chk("stat_clr_misses", stat_misses_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
